// File: rtl/fetch_pkg.sv
// Shared types and defaults for the loop-aware fetch stage.
// Imported by the stage top, its IF/ID register and the bench.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    LOOP,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with squash (to a bubble) and hold.
// Squash takes priority over hold.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        squash,
  input  logic [31:0] squash_pc,
  input  ifid_t       d,
  output ifid_t       q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
    end else if (squash) begin
      q <= '{instr: NOP_INSTR, pc: squash_pc, valid: 1'b0};
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/loop_fetch_stage.sv
// Fetch stage behind the loop detector: owns the PC and IF/ID,
// choosing memory or loop-buffer instructions each cycle.
module loop_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic             block_signal,
  input  logic [31:0]      out_instruction,
  input  logic [31:0]      new_pc,
  input  logic             flush,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             stall,
  output logic [31:0]      curr_PC,
  output logic [31:0]      instruction,
  output logic             ifid_valid,
  output logic             replay_advance,
  output logic             mispredict,
  output logic [CNT_W-1:0] replay_cnt
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d, pc_prev_q;
  logic [31:0]      redir_pc, squash_pc;
  logic             redir, drain_like;
  logic             ev_redir, ev_stall, ev_drain, ev_loop;
  logic             ifid_hold, ifid_squash;
  ifid_t            ifid_d, ifid_q;
  logic             mispredict_q;
  logic [CNT_W-1:0] cnt_q;

  assign redir      = ex_redirect | flush;
  assign redir_pc   = ex_redirect ? ex_target : new_pc;
  // Leaving LOOP behaves exactly like a DRAIN from the held pc
  assign drain_like = (state_q == DRAIN) |
                      ((state_q == LOOP) & ~block_signal);

  assign ev_redir = redir;
  assign ev_stall = ~redir & stall;
  assign ev_drain = ~redir & ~stall & drain_like;
  assign ev_loop  = ~redir & ~stall & ~drain_like & block_signal;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_hold   = 1'b0;
    ifid_squash = 1'b0;
    squash_pc   = pc_q;
    ifid_d      = '{instr: imem_rdata, pc: pc_prev_q, valid: 1'b1};
    unique case (1'b1)
      ev_redir: begin
        ifid_squash = 1'b1;
        squash_pc   = redir_pc;
        pc_d        = redir_pc;
        state_d     = DRAIN;
      end
      ev_stall: begin
        ifid_hold = 1'b1;
        // The word in flight is dropped; rewind so DRAIN reissues it
        if (state_q == FETCH) begin
          pc_d    = pc_prev_q;
          state_d = DRAIN;
        end
      end
      ev_drain: begin
        ifid_squash = 1'b1;
        pc_d        = pc_q + 32'd4;
        state_d     = block_signal ? LOOP : FETCH;
      end
      ev_loop: begin
        ifid_d  = '{instr: out_instruction, pc: new_pc, valid: 1'b1};
        state_d = LOOP;
      end
      default: begin
        pc_d    = pc_q + 32'd4;
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= DRAIN;
      pc_q         <= RESET_PC;
      pc_prev_q    <= RESET_PC;
      mispredict_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_prev_q    <= pc_q;
      mispredict_q <= ex_redirect;
      if (replay_advance) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .hold     (ifid_hold),
    .squash   (ifid_squash),
    .squash_pc(squash_pc),
    .d        (ifid_d),
    .q        (ifid_q)
  );

  assign imem_addr      = pc_q;
  assign imem_req       = ~stall &
                          ((state_q == DRAIN) | ~block_signal);
  assign replay_advance = ev_loop;
  assign curr_PC        = ifid_q.pc;
  assign instruction    = ifid_q.instr;
  assign ifid_valid     = ifid_q.valid;
  assign mispredict     = mispredict_q;
  assign replay_cnt     = cnt_q;

endmodule

// File: tb/tb_loop_fetch_stage.sv
// Scoreboard bench for loop_fetch_stage with a 1-cycle memory model.
// Inputs change at negedge; outputs are sampled at negedge / negedge+1.
module tb_loop_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        block_signal;
  logic [31:0] out_instruction;
  logic [31:0] new_pc;
  logic        flush;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        stall;
  logic [31:0] curr_PC;
  logic [31:0] instruction;
  logic        ifid_valid;
  logic        replay_advance;
  logic        mispredict;
  logic [15:0] replay_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_e;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

  loop_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rdata     (imem_rdata),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .block_signal   (block_signal),
    .out_instruction(out_instruction),
    .new_pc         (new_pc),
    .flush          (flush),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .stall          (stall),
    .curr_PC        (curr_PC),
    .instruction    (instruction),
    .ifid_valid     (ifid_valid),
    .replay_advance (replay_advance),
    .mispredict     (mispredict),
    .replay_cnt     (replay_cnt)
  );

  task automatic test_reset;
    reset = 1'b0; block_signal = 1'b0; out_instruction = 32'h0;
    new_pc = 32'h0; flush = 1'b0; ex_redirect = 1'b0;
    ex_target = 32'h0; stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({imem_addr, instruction, curr_PC} !== {32'h100, NOP, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_regs: addr/instr/pc %h/%h/%h want 100/13/0",
               imem_addr, instruction, curr_PC);
    end
    n_tests++;
    if ({ifid_valid, mispredict, replay_cnt} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_flags: valid/mis/cnt %b/%b/%0d want 0/0/0",
               ifid_valid, mispredict, replay_cnt);
    end
    n_tests++;
    if ({imem_req, replay_advance} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_req: req/adv %b/%b want 1/0",
               imem_req, replay_advance);
    end
  endtask

  task automatic test_fetch;
    reset = 1'b1;
    sb_q.push_back({mem_word(32'h100), 32'h100});
    sb_q.push_back({mem_word(32'h104), 32'h104});
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_tests++;
      if (imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch_req: cycle %0d got %b want 1", i, imem_req);
      end
      @(negedge clk);
      n_tests++;
      if (imem_addr !== 32'h100 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL fetch_addr: got %h want %h",
                 imem_addr, 32'h100 + 32'(4 * i));
      end
      n_tests++;
      if (i == 1) begin
        if ({ifid_valid, instruction} !== {1'b0, NOP}) begin
          n_fail++;
          $display("FAIL fetch_drain: valid/instr %b/%h want 0/13",
                   ifid_valid, instruction);
        end
      end else if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL fetch_sb: got empty queue want entry");
      end else begin
        exp_e = sb_q.pop_front();
        if ({instruction, curr_PC, ifid_valid} !== {exp_e, 1'b1}) begin
          n_fail++;
          $display("FAIL fetch_ifid: got %h/%h/%b want %h/%h/1",
                   instruction, curr_PC, ifid_valid,
                   exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  endtask

  task automatic test_loop;
    logic [31:0] tbl[4] = '{32'h13, 32'h14, 32'h15, 32'hFC000AE3};
    for (int k = 0; k < 4; k++) begin
      block_signal    = 1'b1;
      new_pc          = 32'h100 + 32'(4 * k);
      out_instruction = tbl[k];
      sb_q.push_back({tbl[k], new_pc});
      #1;
      n_tests++;
      if ({imem_req, replay_advance} !== 2'b01) begin
        n_fail++;
        $display("FAIL loop_ctl: req/adv %b/%b want 0/1",
                 imem_req, replay_advance);
      end
      @(negedge clk);
      exp_cnt++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL loop_sb: got empty queue want entry");
      end else begin
        exp_e = sb_q.pop_front();
        if ({instruction, curr_PC, ifid_valid} !== {exp_e, 1'b1}) begin
          n_fail++;
          $display("FAIL loop_ifid: got %h/%h/%b want %h/%h/1",
                   instruction, curr_PC, ifid_valid,
                   exp_e[63:32], exp_e[31:0]);
        end
      end
      n_tests++;
      if ({replay_cnt, imem_addr} !== {16'(exp_cnt), 32'h10C}) begin
        n_fail++;
        $display("FAIL loop_cnt: cnt/addr %0d/%h want %0d/10c",
                 replay_cnt, imem_addr, exp_cnt);
      end
    end
  endtask

  task automatic test_stall;
    stall           = 1'b1;
    new_pc          = 32'h100;
    out_instruction = 32'h13;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({imem_req, replay_advance} !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_ctl: req/adv %b/%b want 0/0",
                 imem_req, replay_advance);
      end
      @(negedge clk);
      n_tests++;
      if ({instruction, curr_PC, replay_cnt} !==
          {32'hFC000AE3, 32'h10C, 16'(exp_cnt)}) begin
        n_fail++;
        $display("FAIL stall_hold: got %h/%h/%0d want fc000ae3/10c/%0d",
                 instruction, curr_PC, replay_cnt, exp_cnt);
      end
    end
    stall = 1'b0;
    sb_q.push_back({32'h13, 32'h100});
    #1;
    n_tests++;
    if (replay_advance !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: adv %b want 1", replay_advance);
    end
    @(negedge clk);
    exp_cnt++;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL stall_sb: got empty queue want entry");
    end else begin
      exp_e = sb_q.pop_front();
      if ({instruction, curr_PC, replay_cnt} !==
          {exp_e, 16'(exp_cnt)}) begin
        n_fail++;
        $display("FAIL stall_resume: got %h/%h/%0d want %h/%h/%0d",
                 instruction, curr_PC, replay_cnt,
                 exp_e[63:32], exp_e[31:0], exp_cnt);
      end
    end
  endtask

  task automatic test_flush;
    flush           = 1'b1;
    new_pc          = 32'h110;
    out_instruction = 32'h14;
    #1;
    n_tests++;
    if (replay_advance !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_adv: got %b want 0", replay_advance);
    end
    @(negedge clk);
    n_tests++;
    if ({ifid_valid, instruction, imem_addr, replay_cnt} !==
        {1'b0, NOP, 32'h110, 16'(exp_cnt)}) begin
      n_fail++;
      $display("FAIL flush_squash: got %b/%h/%h/%0d want 0/13/110/%0d",
               ifid_valid, instruction, imem_addr, replay_cnt, exp_cnt);
    end
    flush        = 1'b0;
    block_signal = 1'b0;
    sb_q.push_back({mem_word(32'h110), 32'h110});
    #1;
    n_tests++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_req: got %b want 1", imem_req);
    end
    @(negedge clk);
    n_tests++;
    if ({imem_addr, ifid_valid} !== {32'h114, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_drain: addr/valid %h/%b want 114/0",
               imem_addr, ifid_valid);
    end
    @(negedge clk);
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL flush_sb: got empty queue want entry");
    end else begin
      exp_e = sb_q.pop_front();
      if ({instruction, curr_PC, ifid_valid} !== {exp_e, 1'b1}) begin
        n_fail++;
        $display("FAIL flush_first: got %h/%h/%b want %h/%h/1",
                 instruction, curr_PC, ifid_valid,
                 exp_e[63:32], exp_e[31:0]);
      end
    end
  endtask

  task automatic test_redirect;
    ex_redirect = 1'b1;
    ex_target   = 32'h200;
    flush       = 1'b1;
    new_pc      = 32'h110;
    @(negedge clk);
    n_tests++;
    if ({imem_addr, ifid_valid, instruction, mispredict} !==
        {32'h200, 1'b0, NOP, 1'b1}) begin
      n_fail++;
      $display("FAIL redir_take: got %h/%b/%h/%b want 200/0/13/1",
               imem_addr, ifid_valid, instruction, mispredict);
    end
    ex_redirect = 1'b0;
    flush       = 1'b0;
    sb_q.push_back({mem_word(32'h200), 32'h200});
    @(negedge clk);
    n_tests++;
    if ({mispredict, ifid_valid, imem_addr} !== {1'b0, 1'b0, 32'h204}) begin
      n_fail++;
      $display("FAIL redir_drain: mis/valid/addr %b/%b/%h want 0/0/204",
               mispredict, ifid_valid, imem_addr);
    end
    @(negedge clk);
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL redir_sb: got empty queue want entry");
    end else begin
      exp_e = sb_q.pop_front();
      if ({instruction, curr_PC, ifid_valid, mispredict} !==
          {exp_e, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL redir_first: got %h/%h/%b/%b want %h/%h/1/0",
                 instruction, curr_PC, ifid_valid, mispredict,
                 exp_e[63:32], exp_e[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid_loop;
    block_signal    = 1'b1;
    new_pc          = 32'h100;
    out_instruction = 32'h15;
    sb_q.push_back({32'h15, 32'h100});
    @(negedge clk);
    exp_cnt++;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL rst_loop_sb: got empty queue want entry");
    end else begin
      exp_e = sb_q.pop_front();
      if ({instruction, curr_PC, replay_cnt} !==
          {exp_e, 16'(exp_cnt)}) begin
        n_fail++;
        $display("FAIL rst_loop_enter: got %h/%h/%0d want %h/%h/%0d",
                 instruction, curr_PC, replay_cnt,
                 exp_e[63:32], exp_e[31:0], exp_cnt);
      end
    end
    reset = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    exp_cnt = 0;
    n_tests++;
    if ({imem_addr, replay_cnt, ifid_valid, instruction} !==
        {32'h100, 16'h0, 1'b0, NOP}) begin
      n_fail++;
      $display("FAIL rst_loop_regs: got %h/%0d/%b/%h want 100/0/0/13",
               imem_addr, replay_cnt, ifid_valid, instruction);
    end
    stall = 1'b0;
    #1;
    n_tests++;
    if ({imem_req, replay_advance} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_loop_ctl: req/adv %b/%b want 1/0",
               imem_req, replay_advance);
    end
    @(negedge clk);
    reset        = 1'b1;
    block_signal = 1'b0;
    sb_q.push_back({mem_word(32'h100), 32'h100});
    @(negedge clk);
    n_tests++;
    if ({imem_addr, ifid_valid} !== {32'h104, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_loop_drain: addr/valid %h/%b want 104/0",
               imem_addr, ifid_valid);
    end
    @(negedge clk);
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL rst_loop_sb2: got empty queue want entry");
    end else begin
      exp_e = sb_q.pop_front();
      if ({instruction, curr_PC, ifid_valid} !== {exp_e, 1'b1}) begin
        n_fail++;
        $display("FAIL rst_loop_fetch: got %h/%h/%b want %h/%h/1",
                 instruction, curr_PC, ifid_valid,
                 exp_e[63:32], exp_e[31:0]);
      end
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries want 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_loop();
    test_stall();
    test_flush();
    test_redirect();
    test_reset_mid_loop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
